// File: rtl/accept_coin_and_dispense_pkg.sv
// Shared definitions for the coin-accept / dispense block: default sizes,
// FSM state encoding and a small saturating-subtract helper.
package accept_coin_and_dispense_pkg;

    localparam int kNumCoinsDef  = 3;
    localparam int kNumItemsDef  = 4;
    localparam int kTotalBitsDef = 31;
    localparam int kArithW       = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        RETURN = 2'd2
    } state_e;

    // Subtract b from a, clamping at zero instead of wrapping.
    function automatic logic [kArithW-1:0] floor_sub(input logic [kArithW-1:0] a,
                                                     input logic [kArithW-1:0] b);
        logic [kArithW-1:0] r;
        r = (b >= a) ? '0 : (a - b);
        return r;
    endfunction

endpackage

// File: rtl/accept_coin_and_dispense_if.sv
// Bus bundle between the vending front end (master) and the coin-accept /
// dispense block (slave).
interface accept_coin_and_dispense_if
    import accept_coin_and_dispense_pkg::*;
#(
    parameter int kNumCoins  = kNumCoinsDef,
    parameter int kNumItems  = kNumItemsDef,
    parameter int kTotalBits = kTotalBitsDef
);
    logic [kNumCoins-1:0]              i_input_coin;
    logic [kNumItems-1:0]              i_select_item;
    logic [kNumCoins-1:0]              i_return_coin;
    logic [kNumCoins-1:0][kArithW-1:0] coin_value;
    logic [kNumItems-1:0][kArithW-1:0] item_price;
    logic [kTotalBits-1:0]             current_total;
    logic [kNumItems-1:0]              o_output_item;
    logic [kNumItems-1:0]              o_available_item;
    logic                              o_coin_reject;

    modport master (
        output i_input_coin, i_select_item, i_return_coin, coin_value, item_price,
        input  current_total, o_output_item, o_available_item, o_coin_reject
    );

    modport slave (
        input  i_input_coin, i_select_item, i_return_coin, coin_value, item_price,
        output current_total, o_output_item, o_available_item, o_coin_reject
    );
endinterface

// File: rtl/accept_coin_and_dispense_coin_sum.sv
// Sums the values of every coin type whose bit is set in a coin mask.
// Used once for inserted coins and once for returned coins.
module coin_sum
    import accept_coin_and_dispense_pkg::*;
#(
    parameter int kNumCoins = kNumCoinsDef
) (
    input  logic [kNumCoins-1:0]              coins_i,
    input  logic [kNumCoins-1:0][kArithW-1:0] values_i,
    output logic [kArithW-1:0]                sum_o
);

    // Masked accumulation of the selected coin values.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (coins_i[i]) begin
                sum_o = sum_o + values_i[i];
            end
        end
    end

endmodule

// File: rtl/accept_coin_and_dispense.sv
// Coin acceptance, item dispensing and change-return bookkeeping for a
// vending machine. Holds the registered balance and a three-state FSM.
module accept_coin_and_dispense
    import accept_coin_and_dispense_pkg::*;
#(
    parameter int kNumCoins  = kNumCoinsDef,
    parameter int kNumItems  = kNumItemsDef,
    parameter int kTotalBits = kTotalBitsDef
) (
    input logic                       clk,
    input logic                       reset_n,
    accept_coin_and_dispense_if.slave bus
);

    // Largest representable balance, held one bit wider so the overflow
    // compare cannot itself wrap when kTotalBits is 32.
    localparam logic [kArithW:0] kMaxBal = (33'd1 << kTotalBits) - 33'd1;

    state_e                state_q, state_d;
    logic [kTotalBits-1:0] total_q, total_d;
    logic [kNumItems-1:0]  item_q, item_d;
    logic                  reject_q, reject_d;

    logic [kArithW-1:0]    ins_sum;
    logic [kArithW-1:0]    ret_sum;
    logic [kArithW-1:0]    total32;
    logic [kArithW-1:0]    price_sel;
    logic [kArithW-1:0]    nxt32;
    logic [kArithW:0]      ins_check;
    logic [kNumItems-1:0]  sel_onehot;
    logic                  sel_found;
    logic                  buy;
    logic                  coin_present;
    logic                  coin_ovf;
    logic                  ret_active;

    assign total32 = kArithW'(total_q);

    coin_sum #(.kNumCoins(kNumCoins)) u_ins_sum (
        .coins_i  (bus.i_input_coin),
        .values_i (bus.coin_value),
        .sum_o    (ins_sum)
    );

    coin_sum #(.kNumCoins(kNumCoins)) u_ret_sum (
        .coins_i  (bus.i_return_coin),
        .values_i (bus.coin_value),
        .sum_o    (ret_sum)
    );

    // Pick the lowest-indexed requested item and its price.
    always_comb begin
        sel_found  = 1'b0;
        sel_onehot = '0;
        price_sel  = '0;
        for (int i = kNumItems - 1; i >= 0; i--) begin
            if (bus.i_select_item[i]) begin
                sel_found     = 1'b1;
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
                price_sel     = bus.item_price[i];
            end
        end
    end

    // Availability flags follow the registered balance only.
    always_comb begin
        bus.o_available_item = '0;
        for (int i = 0; i < kNumItems; i++) begin
            bus.o_available_item[i] = (bus.item_price[i] <= total32);
        end
    end

    // Purchase, insertion-overflow and return qualifiers.
    always_comb begin
        ret_active   = |bus.i_return_coin;
        coin_present = |bus.i_input_coin;
        ins_check    = {1'b0, total32} + {1'b0, ins_sum};
        coin_ovf     = (ins_check > kMaxBal);
        buy          = sel_found && (price_sel <= total32);
    end

    // Next-state, next-balance and pulse generation.
    always_comb begin
        state_d  = state_q;
        total_d  = total_q;
        item_d   = '0;
        reject_d = 1'b0;
        nxt32    = total32;
        if (ret_active) begin
            // Change payout: coins and selections are ignored, balance floors at 0.
            nxt32   = floor_sub(total32, ret_sum);
            total_d = kTotalBits'(nxt32);
            if ((state_q == RETURN) && (nxt32 == '0)) begin
                state_d = IDLE;
            end else begin
                state_d = RETURN;
            end
        end else if (state_q == RETURN) begin
            state_d = (total32 == '0) ? IDLE : CREDIT;
        end else begin
            // The overflow test covers the insertion alone; a same-cycle
            // purchase is still honoured when the coins are refused.
            nxt32 = total32;
            if (coin_present) begin
                if (coin_ovf) begin
                    reject_d = 1'b1;
                end else begin
                    nxt32 = nxt32 + ins_sum;
                end
            end
            if (buy) begin
                nxt32  = nxt32 - price_sel;
                item_d = sel_onehot;
            end
            total_d = kTotalBits'(nxt32);
            state_d = (nxt32 == '0) ? IDLE : CREDIT;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            total_q  <= '0;
            item_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            item_q   <= item_d;
            reject_q <= reject_d;
        end
    end

    assign bus.current_total = total_q;
    assign bus.o_output_item = item_q;
    assign bus.o_coin_reject = reject_q;

endmodule

// File: tb/tb_accept_coin_and_dispense.sv
// Directed testbench for accept_coin_and_dispense.
// coin_value = {100, 500, 1000}; item_price = {400, 500, 1000, 2000}.
module tb_accept_coin_and_dispense;
    import accept_coin_and_dispense_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    accept_coin_and_dispense_if #(.kNumCoins(3), .kNumItems(4), .kTotalBits(31)) bus ();

    accept_coin_and_dispense #(.kNumCoins(3), .kNumItems(4), .kTotalBits(31)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_input_coin  = '0;
        bus.i_select_item = '0;
        bus.i_return_coin = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.current_total !== 31'd0) begin errors++; $display("FAIL reset_total: got %0d want 0", bus.current_total); end
        checks++; if (bus.o_output_item !== 4'b0000) begin errors++; $display("FAIL reset_item: got %b want 0000", bus.o_output_item); end
        checks++; if (bus.o_coin_reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %b want 0", bus.o_coin_reject); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
        checks++; if (bus.o_available_item !== 4'b0000) begin errors++; $display("FAIL reset_avail: got %b want 0000", bus.o_available_item); end
        reset_n = 1'b1;
    endtask

    task automatic test_insert();
        bus.i_input_coin = 3'b010;
        tick();
        checks++; if (bus.current_total !== 31'd500) begin errors++; $display("FAIL ins500_total: got %0d want 500", bus.current_total); end
        checks++; if (dut.state_q !== CREDIT) begin errors++; $display("FAIL ins500_state: got %0d want %0d", int'(dut.state_q), int'(CREDIT)); end
        bus.i_input_coin = 3'b001;
        tick();
        clear_inputs();
        checks++; if (bus.current_total !== 31'd600) begin errors++; $display("FAIL ins100_total: got %0d want 600", bus.current_total); end
        checks++; if (dut.state_q !== CREDIT) begin errors++; $display("FAIL ins100_state: got %0d want %0d", int'(dut.state_q), int'(CREDIT)); end
        checks++; if (bus.o_available_item !== 4'b0011) begin errors++; $display("FAIL ins_avail: got %b want 0011", bus.o_available_item); end
    endtask

    task automatic test_purchase();
        bus.i_select_item = 4'b0001;
        tick();
        clear_inputs();
        checks++; if (bus.o_output_item !== 4'b0001) begin errors++; $display("FAIL buy0_pulse: got %b want 0001", bus.o_output_item); end
        checks++; if (bus.current_total !== 31'd200) begin errors++; $display("FAIL buy0_total: got %0d want 200", bus.current_total); end
        tick();
        checks++; if (bus.o_output_item !== 4'b0000) begin errors++; $display("FAIL buy0_pulse_end: got %b want 0000", bus.o_output_item); end
        checks++; if (bus.current_total !== 31'd200) begin errors++; $display("FAIL buy0_hold: got %0d want 200", bus.current_total); end
    endtask

    task automatic test_unaffordable();
        bus.i_select_item = 4'b1111;
        tick();
        checks++; if (bus.o_output_item !== 4'b0000) begin errors++; $display("FAIL unaff_pulse: got %b want 0000", bus.o_output_item); end
        checks++; if (bus.current_total !== 31'd200) begin errors++; $display("FAIL unaff_total: got %0d want 200", bus.current_total); end
        // Coin arriving with the selection does not make it affordable yet.
        bus.i_input_coin = 3'b100;
        tick();
        clear_inputs();
        checks++; if (bus.current_total !== 31'd1200) begin errors++; $display("FAIL samecyc_total: got %0d want 1200", bus.current_total); end
        checks++; if (bus.o_output_item !== 4'b0000) begin errors++; $display("FAIL samecyc_pulse: got %b want 0000", bus.o_output_item); end
    endtask

    task automatic test_priority_and_combined();
        // 1200: all four requested, only item0 (400) is served.
        bus.i_select_item = 4'b1111;
        tick();
        clear_inputs();
        checks++; if (bus.o_output_item !== 4'b0001) begin errors++; $display("FAIL prio_pulse: got %b want 0001", bus.o_output_item); end
        checks++; if (bus.current_total !== 31'd800) begin errors++; $display("FAIL prio_total: got %0d want 800", bus.current_total); end
        // 800 + 100 - 400 = 500
        bus.i_select_item = 4'b0001;
        bus.i_input_coin  = 3'b001;
        tick();
        clear_inputs();
        checks++; if (bus.current_total !== 31'd500) begin errors++; $display("FAIL combo_total: got %0d want 500", bus.current_total); end
        checks++; if (bus.o_output_item !== 4'b0001) begin errors++; $display("FAIL combo_pulse: got %b want 0001", bus.o_output_item); end
        // 500 - 500 = 0 -> back to IDLE
        bus.i_select_item = 4'b0010;
        tick();
        clear_inputs();
        checks++; if (bus.current_total !== 31'd0) begin errors++; $display("FAIL zero_total: got %0d want 0", bus.current_total); end
        checks++; if (bus.o_output_item !== 4'b0010) begin errors++; $display("FAIL zero_pulse: got %b want 0010", bus.o_output_item); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL zero_state: got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
    endtask

    task automatic test_return();
        do_reset();
        bus.i_input_coin = 3'b101;
        tick();
        clear_inputs();
        checks++; if (bus.current_total !== 31'd1100) begin errors++; $display("FAIL ret_setup: got %0d want 1100", bus.current_total); end
        bus.i_return_coin = 3'b100;
        tick();
        checks++; if (bus.current_total !== 31'd100) begin errors++; $display("FAIL ret1_total: got %0d want 100", bus.current_total); end
        checks++; if (dut.state_q !== RETURN) begin errors++; $display("FAIL ret1_state: got %0d want %0d", int'(dut.state_q), int'(RETURN)); end
        bus.i_return_coin = 3'b001;
        bus.i_input_coin  = 3'b010;
        tick();
        clear_inputs();
        checks++; if (bus.current_total !== 31'd0) begin errors++; $display("FAIL ret2_total: got %0d want 0", bus.current_total); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ret2_state: got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
        checks++; if (bus.o_coin_reject !== 1'b0) begin errors++; $display("FAIL ret2_reject: got %b want 0", bus.o_coin_reject); end
        // Return request while idle: one cycle in RETURN at 0, then IDLE.
        bus.i_return_coin = 3'b001;
        tick();
        clear_inputs();
        checks++; if (dut.state_q !== RETURN) begin errors++; $display("FAIL idleret_state: got %0d want %0d", int'(dut.state_q), int'(RETURN)); end
        checks++; if (bus.current_total !== 31'd0) begin errors++; $display("FAIL idleret_total: got %0d want 0", bus.current_total); end
        tick();
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL idleret_back: got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
        // 1500 -> return 1000 -> 500 RETURN -> CREDIT -> return 1500 floors at 0.
        bus.i_input_coin = 3'b110;
        tick();
        bus.i_input_coin  = 3'b000;
        bus.i_return_coin = 3'b100;
        tick();
        clear_inputs();
        checks++; if (bus.current_total !== 31'd500) begin errors++; $display("FAIL ret3_total: got %0d want 500", bus.current_total); end
        tick();
        checks++; if (dut.state_q !== CREDIT) begin errors++; $display("FAIL ret3_credit: got %0d want %0d", int'(dut.state_q), int'(CREDIT)); end
        bus.i_return_coin = 3'b110;
        tick();
        clear_inputs();
        checks++; if (bus.current_total !== 31'd0) begin errors++; $display("FAIL floor_total: got %0d want 0", bus.current_total); end
        checks++; if (dut.state_q !== RETURN) begin errors++; $display("FAIL floor_state: got %0d want %0d", int'(dut.state_q), int'(RETURN)); end
        tick();
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL floor_idle: got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.coin_value[0] = 32'd2147483048;
        bus.i_input_coin  = 3'b001;
        tick();
        clear_inputs();
        bus.coin_value[0] = 32'd100;
        checks++; if (bus.current_total !== 31'd2147483048) begin errors++; $display("FAIL ovf_setup: got %0d want 2147483048", bus.current_total); end
        bus.i_input_coin = 3'b100;
        tick();
        clear_inputs();
        checks++; if (bus.o_coin_reject !== 1'b1) begin errors++; $display("FAIL ovf_reject: got %b want 1", bus.o_coin_reject); end
        checks++; if (bus.current_total !== 31'd2147483048) begin errors++; $display("FAIL ovf_total: got %0d want 2147483048", bus.current_total); end
        tick();
        checks++; if (bus.o_coin_reject !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b want 0", bus.o_coin_reject); end
        // Exactly reaching the maximum is accepted.
        bus.coin_value[1] = 32'd599;
        bus.i_input_coin  = 3'b010;
        tick();
        clear_inputs();
        bus.coin_value[1] = 32'd500;
        checks++; if (bus.current_total !== 31'd2147483647) begin errors++; $display("FAIL max_total: got %0d want 2147483647", bus.current_total); end
        checks++; if (bus.o_coin_reject !== 1'b0) begin errors++; $display("FAIL max_reject: got %b want 0", bus.o_coin_reject); end
    endtask

    task automatic test_reset_priority();
        bus.i_input_coin  = 3'b001;
        bus.i_select_item = 4'b0001;
        reset_n = 1'b0;
        tick();
        checks++; if (bus.current_total !== 31'd0) begin errors++; $display("FAIL rstp_total: got %0d want 0", bus.current_total); end
        checks++; if (bus.o_output_item !== 4'b0000) begin errors++; $display("FAIL rstp_item: got %b want 0000", bus.o_output_item); end
        checks++; if (bus.o_coin_reject !== 1'b0) begin errors++; $display("FAIL rstp_reject: got %b want 0", bus.o_coin_reject); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rstp_state: got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
        reset_n = 1'b1;
        clear_inputs();
        bus.i_input_coin = 3'b100;
        tick();
        bus.i_input_coin  = 3'b000;
        bus.i_return_coin = 3'b001;
        tick();
        checks++; if (dut.state_q !== RETURN) begin errors++; $display("FAIL rstr_setup: got %0d want %0d", int'(dut.state_q), int'(RETURN)); end
        bus.i_input_coin = 3'b010;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_inputs();
        checks++; if (bus.current_total !== 31'd0) begin errors++; $display("FAIL rstr_total: got %0d want 0", bus.current_total); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rstr_state: got %0d want %0d", int'(dut.state_q), int'(IDLE)); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        clear_inputs();
        bus.coin_value[0] = 32'd100;
        bus.coin_value[1] = 32'd500;
        bus.coin_value[2] = 32'd1000;
        bus.item_price[0] = 32'd400;
        bus.item_price[1] = 32'd500;
        bus.item_price[2] = 32'd1000;
        bus.item_price[3] = 32'd2000;
        test_reset();
        test_insert();
        test_purchase();
        test_unaffordable();
        test_priority_and_combined();
        test_return();
        test_overflow();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
